// File: rtl/dac_serializer_pkg.sv
// Shared constants for the I2S DAC serializer: frame slot map and default widths.
package dac_serializer_pkg;

    localparam int unsigned DEF_SAMPLE_W = 16;
    localparam int unsigned DEF_DIV_W    = 8;

    localparam int unsigned SLOT_LAST    = 31;
    localparam int unsigned WS_RISE_SLOT = 15;
    localparam int unsigned WS_FALL_SLOT = 31;
    localparam int unsigned SLOT_W       = $clog2(SLOT_LAST + 1);

    // Word strobe leads each channel MSB by one slot: high for slots 15..30.
    function automatic logic ws_for_slot(input logic [SLOT_W-1:0] b);
        return (b >= SLOT_W'(WS_RISE_SLOT)) && (b != SLOT_W'(WS_FALL_SLOT));
    endfunction

endpackage

// File: rtl/dac_clkdiv.sv
// Serial bit-clock divider: half period of sclk_div+1 cycles, with strobes
// asserted in the cycle whose closing edge toggles sclk.
module dac_clkdiv
    import dac_serializer_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             enable,
    input  logic [DIV_W-1:0] sclk_div,
    output logic             sclk,
    output logic             rise_c,
    output logic             fall_c
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;
    logic             run;
    logic             wrap_c;

    assign wrap_c = enable && run && (cnt == lim);
    assign rise_c = wrap_c && !sclk;
    assign fall_c = wrap_c && sclk;

    // lim holds the divider for the current half period; it only moves at a wrap.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            cnt  <= '0;
            lim  <= '0;
            run  <= 1'b0;
            sclk <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            lim  <= sclk_div;
            run  <= 1'b0;
            sclk <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            lim <= sclk_div;
            run <= 1'b1;
        end else if (wrap_c) begin
            cnt  <= '0;
            lim  <= sclk_div;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dac_serializer.sv
// I2S output stage: double-buffered left/right samples shifted out MSB first,
// with a frame-load interrupt and a sticky underrun flag.
module dac_serializer
    import dac_serializer_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
    parameter int unsigned DIV_W    = DEF_DIV_W
) (
    input  logic                sys_clk,
    input  logic                resetl,
    input  logic                enable,
    input  logic [DIV_W-1:0]    sclk_div,
    input  logic                wr_l,
    input  logic                wr_r,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                clr_underrun,
    output logic                sclk,
    output logic                ws,
    output logic                sdata,
    output logic                frame_irq,
    output logic                underrun
);

    localparam int unsigned WORD_W = 2 * SAMPLE_W;

    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic                fresh_l;
    logic                fresh_r;
    logic [WORD_W-1:0]   shreg;
    logic [SLOT_W-1:0]   slot_nxt;
    logic                fall_c;
    logic                load_c;
    logic                stale_c;
    logic                sclk_rise_unused;

    dac_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
        .sys_clk  (sys_clk),
        .resetl   (resetl),
        .enable   (enable),
        .sclk_div (sclk_div),
        .sclk     (sclk),
        .rise_c   (sclk_rise_unused),
        .fall_c   (fall_c)
    );

    // slot_nxt is the slot entered at the next fall, so idle (slot 31) reads as zero.
    assign load_c  = fall_c && (slot_nxt == '0);
    assign stale_c = load_c && !(fresh_l && fresh_r);
    assign sdata   = shreg[WORD_W-1];

    // Holding registers and flags run regardless of enable.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            hold_l    <= '0;
            hold_r    <= '0;
            fresh_l   <= 1'b0;
            fresh_r   <= 1'b0;
            underrun  <= 1'b0;
            frame_irq <= 1'b0;
        end else begin
            if (wr_l) hold_l <= wdata;
            if (wr_r) hold_r <= wdata;
            fresh_l   <= wr_l || (fresh_l && !load_c);
            fresh_r   <= wr_r || (fresh_r && !load_c);
            underrun  <= stale_c || (underrun && !clr_underrun);
            frame_irq <= load_c;
        end
    end

    // Slot counter, word strobe and shift word advance on sclk falls only.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            slot_nxt <= '0;
            shreg    <= '0;
            ws       <= 1'b0;
        end else if (!enable) begin
            slot_nxt <= '0;
            shreg    <= '0;
            ws       <= 1'b0;
        end else if (fall_c) begin
            slot_nxt <= slot_nxt + SLOT_W'(1);
            ws       <= ws_for_slot(slot_nxt);
            shreg    <= load_c ? {hold_l, hold_r} : {shreg[WORD_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: cycle-timed frame model plus directed and random stimulus.
module tb_dac_serializer;

    localparam int unsigned SW = 16;
    localparam int unsigned DW = 8;

    logic          sys_clk = 1'b0;
    logic          resetl;
    logic          enable;
    logic [DW-1:0] sclk_div;
    logic          wr_l;
    logic          wr_r;
    logic [SW-1:0] wdata;
    logic          clr_underrun;
    logic          sclk;
    logic          ws;
    logic          sdata;
    logic          frame_irq;
    logic          underrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    dac_serializer #(.SAMPLE_W(SW), .DIV_W(DW)) dut (
        .sys_clk      (sys_clk),
        .resetl       (resetl),
        .enable       (enable),
        .sclk_div     (sclk_div),
        .wr_l         (wr_l),
        .wr_r         (wr_r),
        .wdata        (wdata),
        .clr_underrun (clr_underrun),
        .sclk         (sclk),
        .ws           (ws),
        .sdata        (sdata),
        .frame_irq    (frame_irq),
        .underrun     (underrun)
    );

    // Reference model: schedules sclk toggles by absolute edge number.
    int          n_edge = 0;
    int          m_next = 0;
    int          m_slot = 31;
    bit          m_run = 0, m_sclk = 0, m_ws = 0, m_sd = 0, m_irq = 0, m_ur = 0;
    bit          m_fl = 0, m_fr = 0, m_act = 0, m_load = 0;
    logic [15:0] m_hl = '0, m_hr = '0;
    logic [31:0] m_word = '0;

    always @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            m_run = 0; m_sclk = 0; m_ws = 0; m_sd = 0; m_irq = 0; m_ur = 0;
            m_fl = 0; m_fr = 0; m_act = 0; m_slot = 31;
            m_hl = '0; m_hr = '0; m_word = '0;
        end else begin
            n_edge++;
            m_irq  = 0;
            m_load = 0;
            if (!enable) begin
                m_run = 0; m_sclk = 0; m_ws = 0; m_sd = 0; m_act = 0; m_slot = 31;
            end else if (!m_run) begin
                m_run  = 1;
                m_next = n_edge + int'(sclk_div) + 1;
            end else if (n_edge == m_next) begin
                m_next = n_edge + int'(sclk_div) + 1;
                m_sclk = !m_sclk;
                if (!m_sclk) begin
                    m_slot = (m_slot + 1) % 32;
                    if (m_slot == 0) begin
                        m_load = 1; m_irq = 1; m_act = 1;
                        m_word = {m_hl, m_hr};
                    end
                    m_ws = (m_slot >= 15) && (m_slot <= 30);
                    m_sd = m_word[31 - m_slot];
                end
            end
            if (m_load && !(m_fl && m_fr)) m_ur = 1;
            else if (clr_underrun)         m_ur = 0;
            if (m_load) begin m_fl = 0; m_fr = 0; end
            if (wr_l) begin m_hl = wdata; m_fl = 1; end
            if (wr_r) begin m_hr = wdata; m_fr = 1; end
        end
    end

    int          tick_n = 0, last_rise = 0, rise_period = 0, rx_count = 0;
    logic        prev_sclk = 1'b0;
    logic [31:0] rx_bits = '0, rx_last = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: compare outputs at the falling edge, capture receiver bits, return after the next rise.
    task automatic tick();
        @(negedge sys_clk);
        tick_n++;
        check("sclk",      32'(sclk),      32'(m_sclk));
        check("ws",        32'(ws),        32'(m_ws));
        check("sdata",     32'(sdata),     32'(m_sd));
        check("frame_irq", 32'(frame_irq), 32'(m_irq));
        check("underrun",  32'(underrun),  32'(m_ur));
        if (!prev_sclk && sclk) begin
            rise_period = tick_n - last_rise;
            last_rise   = tick_n;
            if (m_act) begin
                rx_bits[31 - m_slot] = sdata;
                if (m_slot == 31) begin
                    rx_last = rx_bits;
                    rx_count++;
                end
            end
        end
        prev_sclk = sclk;
        @(posedge sys_clk);
        #2;
    endtask

    task automatic write(input bit l, input bit r, input logic [15:0] d);
        wr_l = l; wr_r = r; wdata = d;
        tick();
        wr_l = 0; wr_r = 0;
    endtask

    task automatic wait_load_next();
        for (int i = 0; i < 3000; i++) begin
            if (enable && m_run && m_sclk && m_slot == 31 && m_next == n_edge + 1) return;
            tick();
        end
        check("timeout_load", 32'd0, 32'd1);
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 3000; i++) begin
            if (m_slot == s && m_sclk) return;
            tick();
        end
        check("timeout_slot", 32'd0, 32'd1);
    endtask

    task automatic wait_frame();
        int c0 = rx_count;
        for (int i = 0; i < 3000; i++) begin
            if (rx_count != c0) return;
            tick();
        end
        check("timeout_frame", 32'd0, 32'd1);
    endtask

    // Cycles from the edge that first sees enable high to the frame load edge.
    task automatic irq_latency(output int cyc);
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (frame_irq) begin
                cyc = i - 1;
                return;
            end
        end
        cyc = -1;
    endtask

    initial begin
        int cyc;
        int irqs;
        resetl = 0; enable = 0; wr_l = 0; wr_r = 0; wdata = '0;
        clr_underrun = 0; sclk_div = 8'd3;
        repeat (3) tick();
        resetl = 1;
        tick();

        // First frame with fresh samples, divider 3 -> 8-cycle sclk.
        write(1, 0, 16'h8001);
        write(0, 1, 16'h7FFF);
        enable = 1;
        irq_latency(cyc);
        check("first_irq_latency", 32'(cyc), 32'd8);
        wait_frame();
        check("frame1_bits", rx_last, 32'h8001_7FFF);
        check("frame1_underrun", 32'(underrun), 32'd0);
        check("sclk_period_div3", 32'(rise_period), 32'd8);

        // Second frame replays and flags underrun.
        wait_frame();
        check("frame2_replay", rx_last, 32'h8001_7FFF);
        check("underrun_set", 32'(underrun), 32'd1);
        clr_underrun = 1; tick(); clr_underrun = 0;
        check("underrun_clr", 32'(underrun), 32'd0);
        wait_load_next();
        clr_underrun = 1; tick(); clr_underrun = 0;
        check("underrun_set_wins", 32'(underrun), 32'd1);
        check("irq_on_load", 32'(frame_irq), 32'd1);

        // Write coinciding with a frame load.
        clr_underrun = 1; tick(); clr_underrun = 0;
        write(1, 0, 16'hAAAA);
        write(0, 1, 16'h5555);
        wait_load_next();
        wr_l = 1; wdata = 16'h1234; tick(); wr_l = 0;
        check("load_with_write_ur", 32'(underrun), 32'd0);
        write(0, 1, 16'h0F0F);
        wait_frame();
        check("load_uses_old_left", rx_last, 32'hAAAA_5555);
        wait_frame();
        check("write_at_load_next", rx_last, 32'h1234_0F0F);
        check("write_at_load_fresh", 32'(underrun), 32'd0);

        // Divider change mid-frame.
        wait_load_next();
        tick();
        write(1, 0, 16'hC3A5);
        write(0, 1, 16'h5A3C);
        clr_underrun = 1; tick(); clr_underrun = 0;
        wait_load_next();
        tick();
        wait_slot(5);
        tick();
        sclk_div = 8'd0;
        wait_frame();
        check("div_change_bits", rx_last, 32'hC3A5_5A3C);
        check("sclk_period_div0", 32'(rise_period), 32'd2);

        // Enable dropped mid-frame, then restarted.
        wait_load_next();
        tick();
        write(1, 0, 16'hBEEF);
        write(0, 1, 16'hCAFE);
        sclk_div = 8'd3;
        wait_slot(10);
        enable = 0;
        tick();
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_ws", 32'(ws), 32'd0);
        check("abort_sdata", 32'(sdata), 32'd0);
        irqs = 0;
        repeat (20) begin
            tick();
            irqs += int'(frame_irq);
        end
        check("idle_no_irq", 32'(irqs), 32'd0);
        enable = 1;
        irq_latency(cyc);
        check("reenable_irq_latency", 32'(cyc), 32'd8);
        wait_frame();
        check("reenable_frame", rx_last, 32'hBEEF_CAFE);

        // Asynchronous reset mid-frame with sclk high and ws high.
        wait_slot(20);
        resetl = 0;
        #1;
        check("rst_async_sclk", 32'(sclk), 32'd0);
        check("rst_async_ws", 32'(ws), 32'd0);
        check("rst_async_sdata", 32'(sdata), 32'd0);
        check("rst_async_irq", 32'(frame_irq), 32'd0);
        check("rst_async_underrun", 32'(underrun), 32'd0);
        tick();
        tick();
        resetl = 1;
        irq_latency(cyc);
        check("post_reset_irq_latency", 32'(cyc), 32'd8);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            wr_l  = ($urandom_range(7) == 0);
            wr_r  = ($urandom_range(7) == 0);
            wdata = 16'($urandom);
            clr_underrun = ($urandom_range(15) == 0);
            if ($urandom_range(299) == 0) sclk_div = 8'($urandom_range(3));
            if ($urandom_range(999) == 0) enable = ~enable;
            else if (!enable && $urandom_range(19) == 0) enable = 1;
            tick();
        end
        wr_l = 0; wr_r = 0; clr_underrun = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
